// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE then per-class execute
// states, Moore-style outputs with only the branch PC enable depending on zero.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       ir_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       iord,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [1:0] pc_src,
    output logic       ext_op,
    output logic [3:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADR   = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_IEXE   = 4'd8,
        S_IWB    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4
    } alu_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26
    } funct_t;

    state_t cur, nxt;
    alu_t   alu_c;

    logic is_mem, is_rtype, is_iarith, is_branch, is_jump;
    logic pc_en_c, ir_wr_c, mem_rd_c, mem_wr_c, reg_wr_c, illegal_c;

    always_comb begin
        is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
        is_rtype  = (opcode == OP_RTYPE) &&
                    ((funct == FN_ADD) || (funct == FN_ADDU) || (funct == FN_SUB) ||
                     (funct == FN_SUBU) || (funct == FN_AND) || (funct == FN_OR) ||
                     (funct == FN_XOR));
        is_iarith = (opcode == OP_ADDI) || (opcode == OP_ADDIU) || (opcode == OP_ANDI) ||
                    (opcode == OP_ORI) || (opcode == OP_XORI);
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jump   = (opcode == OP_J);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_FETCH;
        else      cur <= nxt;
    end

    always_comb begin
        nxt        = S_FETCH;
        pc_en_c    = 1'b0;
        ir_wr_c    = 1'b0;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        reg_wr_c   = 1'b0;
        illegal_c  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        iord       = 1'b0;
        alu_srca   = 1'b0;
        alu_srcb   = 2'b00;
        pc_src     = 2'b00;
        ext_op     = 1'b0;
        alu_c      = ALU_ADD;

        case (cur)
            S_FETCH: begin
                mem_rd_c = 1'b1;
                ir_wr_c  = 1'b1;
                alu_srcb = 2'b01;
                pc_en_c  = 1'b1;
                nxt      = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target computed here for use in BR.
                alu_srcb = 2'b11;
                ext_op   = 1'b1;
                if (is_mem)         nxt = S_MADR;
                else if (is_rtype)  nxt = S_REXE;
                else if (is_iarith) nxt = S_IEXE;
                else if (is_branch) nxt = S_BR;
                else if (is_jump)   nxt = S_JMP;
                else                illegal_c = 1'b1;
            end
            S_MADR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                ext_op   = 1'b1;
                nxt      = (opcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_rd_c = 1'b1;
                iord     = 1'b1;
                nxt      = S_MWB;
            end
            S_MWB: begin
                reg_wr_c   = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MWR: begin
                mem_wr_c = 1'b1;
                iord     = 1'b1;
            end
            S_REXE: begin
                alu_srca = 1'b1;
                case (funct)
                    FN_SUB, FN_SUBU: alu_c = ALU_SUB;
                    FN_AND:          alu_c = ALU_AND;
                    FN_OR:           alu_c = ALU_OR;
                    FN_XOR:          alu_c = ALU_XOR;
                    default:         alu_c = ALU_ADD;
                endcase
                nxt = S_RWB;
            end
            S_RWB: begin
                reg_wr_c = 1'b1;
                reg_dst  = 1'b1;
            end
            S_IEXE: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                case (opcode)
                    OP_ANDI: alu_c = ALU_AND;
                    OP_ORI:  alu_c = ALU_OR;
                    OP_XORI: alu_c = ALU_XOR;
                    default: begin
                        alu_c  = ALU_ADD;
                        ext_op = 1'b1;
                    end
                endcase
                nxt = S_IWB;
            end
            S_IWB: begin
                reg_wr_c = 1'b1;
            end
            S_BR: begin
                alu_srca = 1'b1;
                alu_c    = ALU_SUB;
                pc_src   = 2'b01;
                pc_en_c  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JMP: begin
                pc_src  = 2'b10;
                pc_en_c = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Strobes are masked by reset directly so they drop without waiting for a clock edge.
    always_comb begin
        pc_en   = pc_en_c   & rst;
        ir_wr   = ir_wr_c   & rst;
        mem_rd  = mem_rd_c  & rst;
        mem_wr  = mem_wr_c  & rst;
        reg_wr  = reg_wr_c  & rst;
        illegal = illegal_c & rst;
        alu_op  = alu_c;
        state   = cur;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against an instruction-level
// model of state sequences and per-state control words.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pc_en, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, iord, alu_srca;
    logic [1:0] alu_srcb, pc_src;
    logic       ext_op, illegal;
    logic [3:0] alu_op, state;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .ir_wr(ir_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .iord(iord),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .pc_src(pc_src), .ext_op(ext_op),
        .alu_op(alu_op), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {pc_en, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, iord,
                  alu_srca, alu_srcb, pc_src, ext_op, alu_op, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (op=%h fn=%h t=%0t)", tag, got, exp,
                     opcode, funct, $time);
        end
    endtask

    // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 I-arith, 4 branch, 5 jump, 6 illegal
    function automatic int classify(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h23: return 0;
            6'h2B: return 1;
            6'h00: return (fn >= 6'h20 && fn <= 6'h26) ? 2 : 6;
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: return 3;
            6'h04, 6'h05: return 4;
            6'h02: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic void state_seq(int cls, output int q[$]);
        case (cls)
            0: q = '{0, 1, 2, 3, 4};
            1: q = '{0, 1, 2, 5};
            2: q = '{0, 1, 6, 7};
            3: q = '{0, 1, 8, 9};
            4: q = '{0, 1, 10};
            5: q = '{0, 1, 11};
            default: q = '{0, 1};
        endcase
    endfunction

    function automatic logic [19:0] exp_out(int st, logic [5:0] op, logic [5:0] fn,
                                            logic z, bit in_reset);
        logic pe, iw, mr, mw, rw, rd, m2r, io, sa, eo, il;
        logic [1:0] sb, ps;
        logic [3:0] ao;
        {pe, iw, mr, mw, rw, rd, m2r, io, sa, eo, il} = '0;
        sb = 2'b00; ps = 2'b00; ao = 4'd0;
        case (st)
            0:  begin mr = 1; iw = 1; sb = 2'b01; pe = 1; end
            1:  begin sb = 2'b11; eo = 1; il = (classify(op, fn) == 6); end
            2:  begin sa = 1; sb = 2'b10; eo = 1; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin
                    sa = 1;
                    if (fn == 6'h22 || fn == 6'h23) ao = 4'd1;
                    else if (fn == 6'h24) ao = 4'd2;
                    else if (fn == 6'h25) ao = 4'd3;
                    else if (fn == 6'h26) ao = 4'd4;
                end
            7:  begin rw = 1; rd = 1; end
            8:  begin
                    sa = 1; sb = 2'b10;
                    if (op == 6'h0C) ao = 4'd2;
                    else if (op == 6'h0D) ao = 4'd3;
                    else if (op == 6'h0E) ao = 4'd4;
                    else eo = 1;
                end
            9:  rw = 1;
            10: begin sa = 1; ao = 4'd1; ps = 2'b01; pe = (op == 6'h05) ? !z : z; end
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        if (in_reset) {pe, iw, mr, mw, rw, il} = '0;
        return {pe, iw, mr, mw, rw, rd, m2r, io, sa, sb, ps, eo, ao, il};
    endfunction

    // Runs one instruction from FETCH; reset_at >= 0 asserts reset during that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int reset_at);
        int seq[$];
        opcode = op;
        funct  = fn;
        state_seq(classify(op, fn), seq);
        foreach (seq[i]) begin
            zero = 1'($urandom_range(0, 1));
            #1;
            check("state", 32'(state), 32'(seq[i]));
            check("ctrl", 32'(obs), 32'(exp_out(seq[i], op, fn, zero, 1'b0)));
            if (reset_at == i) begin
                rst = 1'b0;
                #1;
                check("rst_state", 32'(state), 32'd0);
                check("rst_ctrl", 32'(obs), 32'(exp_out(0, op, fn, zero, 1'b1)));
                @(negedge clk);
                check("rst_hold", 32'(state), 32'd0);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    logic [5:0] legal_ops [11] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h09, 6'h0C,
                                   6'h0D, 6'h0E, 6'h04, 6'h05, 6'h02};

    initial begin
        rst = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctrl", 32'(obs), 32'(exp_out(0, opcode, funct, zero, 1'b1)));
        rst = 1'b1;

        run_instr(6'h23, 6'h00, -1);
        run_instr(6'h00, 6'h22, -1);
        repeat (4) run_instr(6'h04, 6'h00, -1);
        repeat (4) run_instr(6'h05, 6'h00, -1);
        run_instr(6'h0D, 6'h00, -1);
        run_instr(6'h3F, 6'h00, -1);
        run_instr(6'h2B, 6'h00, 3);
        run_instr(6'h00, 6'h2A, -1);
        run_instr(6'h02, 6'h00, -1);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op, fn;
            int ra;
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 10)];
            else                          op = 6'($urandom);
            if (op == 6'h00 && $urandom_range(0, 3) != 0) fn = 6'($urandom_range(32, 38));
            else                                          fn = 6'($urandom);
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, fn, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
